// File: rtl/button_event_arbiter.sv
// Push-button front end: synchronise, debounce, classify short/long presses on release,
// and hand events one at a time to the control FSM with round-robin fairness.
module button_event_arbiter #(
  parameter int N_BTN       = 5,
  parameter int DEB_CYCLES  = 1_000_000,
  parameter int LONG_CYCLES = 50_000_000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_BTN-1:0]         btn_raw,
  output logic [N_BTN-1:0]         btn_level,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [$clog2(N_BTN)-1:0] evt_id,
  output logic                     evt_long,
  output logic                     evt_overflow
);

  localparam int ID_W = $clog2(N_BTN);
  localparam int DW   = $clog2(DEB_CYCLES + 1);
  localparam int HW   = $clog2(LONG_CYCLES + 1);

  typedef enum logic {IDLE, OFFER} state_t;

  logic [N_BTN-1:0] sync1, sync2, level, level_nxt, rise, fall;
  logic [N_BTN-1:0] at_long, pending, pend_nxt, plong, plong_nxt, drop;
  logic [DW-1:0]    deb_cnt  [N_BTN];
  logic [HW-1:0]    hold_cnt [N_BTN];
  logic [ID_W-1:0]  rr_ptr, pick, grant_id;
  logic             grant;
  state_t           state, state_nxt;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  // A change is accepted on the sample after the counter has reached DEB_CYCLES.
  // NOTE: combinational blocks assign a default before any branch so no latch is inferred.
  always_comb begin
    level_nxt = level;
    for (int i = 0; i < N_BTN; i++) begin
      if (sync2[i] != level[i] && deb_cnt[i] == DW'(DEB_CYCLES)) level_nxt[i] = sync2[i];
      at_long[i] = (hold_cnt[i] == HW'(LONG_CYCLES));
    end
  end

  assign rise = level_nxt & ~level;
  assign fall = level & ~level_nxt;

  // NOTE: per-button counter arrays are reset explicitly; they live in flops, not RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        deb_cnt[i]  <= '0;
        hold_cnt[i] <= '0;
      end
    end else begin
      level <= level_nxt;
      for (int i = 0; i < N_BTN; i++) begin
        if (sync2[i] == level[i] || rise[i] || fall[i]) deb_cnt[i] <= '0;
        else                                            deb_cnt[i] <= deb_cnt[i] + DW'(1);
        if (rise[i])                     hold_cnt[i] <= '0;
        else if (level[i] && !at_long[i]) hold_cnt[i] <= hold_cnt[i] + HW'(1);
      end
    end
  end

  // Round-robin search: descending loop so the smallest offset from rr_ptr wins.
  always_comb begin
    int idx;
    pick = rr_ptr;
    for (int k = N_BTN; k >= 1; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_BTN) idx = idx - N_BTN;
      if (pending[idx]) pick = ID_W'(idx);
    end
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    grant_id  = '0;
    case (state)
      IDLE:  if (|pending) begin
               grant     = 1'b1;
               grant_id  = pick;
               state_nxt = OFFER;
             end
      OFFER: if (evt_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A release on a still-pending button is dropped unless that button is granted now.
  always_comb begin
    pend_nxt  = pending;
    plong_nxt = plong;
    drop      = '0;
    if (grant) pend_nxt[grant_id] = 1'b0;
    for (int i = 0; i < N_BTN; i++) begin
      if (fall[i]) begin
        if (pending[i] && !(grant && grant_id == ID_W'(i))) begin
          drop[i] = 1'b1;
        end else begin
          pend_nxt[i]  = 1'b1;
          plong_nxt[i] = at_long[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      pending      <= '0;
      plong        <= '0;
      rr_ptr       <= ID_W'(N_BTN - 1);
      evt_id       <= '0;
      evt_long     <= 1'b0;
      evt_overflow <= 1'b0;
    end else begin
      state        <= state_nxt;
      pending      <= pend_nxt;
      plong        <= plong_nxt;
      evt_overflow <= |drop;
      if (grant) begin
        evt_id   <= grant_id;
        evt_long <= plong[grant_id];
      end
      if (state == OFFER && evt_ready) rr_ptr <= evt_id;
    end
  end

  assign evt_valid = (state == OFFER);
  assign btn_level = level;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Bench for button_event_arbiter: directed scenarios with literal expectations plus
// randomized button activity, all checked each cycle against a behavioural model.
module tb_button_event_arbiter;

  localparam int N = 5;
  localparam int D = 4;
  localparam int L = 16;

  logic         clk, rst_n, evt_valid, evt_ready, evt_long, evt_overflow;
  logic [N-1:0] btn_raw, btn_level;
  logic [2:0]   evt_id;

  button_event_arbiter #(.N_BTN(N), .DEB_CYCLES(D), .LONG_CYCLES(L)) dut (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .btn_level(btn_level),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_id(evt_id),
    .evt_long(evt_long), .evt_overflow(evt_overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_mis = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The level follows the synchronised input once it has disagreed for D+1 samples;
  // a press is long when the level stayed high for more than L cycles after its rise.
  logic [N-1:0] m_s1, m_s2, m_lvl, m_pend, m_plong;
  int           m_run [N];
  int           m_rise_t [N];
  int           m_cyc, m_rr, m_id, m_evcnt;
  bit           m_off, m_long, m_ovf;

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_lvl = '0; m_pend = '0; m_plong = '0;
    for (int i = 0; i < N; i++) begin m_run[i] = 0; m_rise_t[i] = 0; end
    m_cyc = 0; m_rr = N - 1; m_id = 0; m_evcnt = 0;
    m_off = 0; m_long = 0; m_ovf = 0;
  endtask

  task automatic model_step();
    logic [N-1:0] fell, rose, pend_old;
    bit g, ovf;
    int gid;
    fell = '0; rose = '0; g = 0; gid = 0; ovf = 0;
    for (int i = 0; i < N; i++) begin
      if (m_s2[i] == m_lvl[i]) m_run[i] = 0;
      else if (m_run[i] >= D) begin
        if (m_lvl[i]) fell[i] = 1'b1; else rose[i] = 1'b1;
        m_lvl[i] = m_s2[i];
        m_run[i] = 0;
      end else m_run[i]++;
      if (rose[i]) m_rise_t[i] = m_cyc;
    end
    m_s2 = m_s1;
    m_s1 = btn_raw;
    if (!m_off && m_pend != '0) begin
      g = 1;
      for (int k = N; k >= 1; k--) if (m_pend[(m_rr + k) % N]) gid = (m_rr + k) % N;
    end
    if (m_off && evt_ready) begin
      m_off = 0; m_rr = m_id; m_evcnt++;
    end
    pend_old = m_pend;
    if (g) begin
      m_pend[gid] = 1'b0; m_off = 1; m_id = gid; m_long = m_plong[gid];
    end
    for (int i = 0; i < N; i++) begin
      if (fell[i]) begin
        if (pend_old[i] && !(g && gid == i)) ovf = 1;
        else begin
          m_pend[i]  = 1'b1;
          m_plong[i] = ((m_cyc - m_rise_t[i] - 1) >= L);
        end
      end
    end
    m_ovf = ovf;
    m_cyc++;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  // ---------------- compare and DUT observation ----------------
  int tb_cyc = 0;
  int ev_id_q[$], ev_long_q[$], ev_cyc_q[$];
  int ovf_cnt, vld_cnt, rise0;
  bit lvl0_prev;

  always @(posedge clk) tb_cyc++;

  always @(negedge clk) begin
    if (rst_n) begin
      check("btn_level", 32'(btn_level), 32'(m_lvl));
      check("evt_valid", 32'(evt_valid), 32'(m_off));
      check("evt_overflow", 32'(evt_overflow), 32'(m_ovf));
      if (m_off) begin
        check("evt_id", 32'(evt_id), 32'(m_id));
        check("evt_long", 32'(evt_long), 32'(m_long));
      end
      if (evt_valid && evt_ready) begin
        ev_id_q.push_back(int'(evt_id));
        ev_long_q.push_back(int'(evt_long));
        ev_cyc_q.push_back(tb_cyc);
      end
      if (evt_overflow) ovf_cnt++;
      if (evt_valid) vld_cnt++;
      if (btn_level[0] && !lvl0_prev) rise0++;
      lvl0_prev = btn_level[0];
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic clear_logs();
    ev_id_q.delete(); ev_long_q.delete(); ev_cyc_q.delete();
    ovf_cnt = 0; vld_cnt = 0; rise0 = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; btn_raw = '0;
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    clear_logs();
  endtask

  task automatic press(int b, int len);
    btn_raw[b] = 1'b1;
    cyc(len);
    btn_raw[b] = 1'b0;
  endtask

  task automatic wait_evt(string name, int n, int budget);
    int k = 0;
    while (ev_id_q.size() < n && k < budget) begin cyc(1); k++; end
    check(name, ev_id_q.size(), n);
  endtask

  task automatic wait_valid(string name, int budget);
    int k = 0;
    while (!evt_valid && k < budget) begin cyc(1); k++; end
    check(name, 32'(evt_valid), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t_ready;
    int long_len [4] = '{25, 8, 16, 17};
    int long_exp [4] = '{1, 0, 0, 1};
    rst_n = 1'b0; btn_raw = '0; evt_ready = 1'b1;
    clear_logs();
    #1;
    check("rst_btn_level", 32'(btn_level), 0);
    check("rst_evt_valid", 32'(evt_valid), 0);
    check("rst_evt_id", 32'(evt_id), 0);
    check("rst_evt_long", 32'(evt_long), 0);
    check("rst_evt_overflow", 32'(evt_overflow), 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(1);

    // 1. bounce then a short clean press on btn0
    for (int k = 0; k < 6; k++) begin btn_raw[0] = (k % 2 == 0); cyc(2); end
    cyc(8);
    check("bounce_no_event", ev_id_q.size(), 0);
    check("bounce_no_rise", rise0, 0);
    press(0, 10);
    wait_evt("bounce_evt_count", 1, 60);
    check("bounce_id", ev_id_q[0], 0);
    check("bounce_long", ev_long_q[0], 0);
    check("bounce_rise_once", rise0, 1);

    // 2. hold-length classification around the LONG boundary
    for (int k = 0; k < 4; k++) begin
      clear_logs();
      press(2, long_len[k]);
      wait_evt("hold_evt_count", 1, 60);
      check("hold_id", ev_id_q[0], 2);
      check("hold_long", ev_long_q[0], long_exp[k]);
      cyc(3);
    end

    // 3. simultaneous releases on btn1 and btn3, twice
    do_reset();
    for (int r = 0; r < 2; r++) begin
      clear_logs();
      btn_raw[1] = 1'b1; btn_raw[3] = 1'b1;
      cyc(8);
      btn_raw[1] = 1'b0; btn_raw[3] = 1'b0;
      wait_evt("simul_evt_count", 2, 60);
      check("simul_first", ev_id_q[0], 1);
      check("simul_second", ev_id_q[1], 3);
      check("simul_gap", 32'(ev_cyc_q[1] - ev_cyc_q[0] >= 2), 1);
    end

    // 4. backpressure on a btn4 event
    clear_logs();
    evt_ready = 1'b0;
    press(4, 8);
    wait_valid("bp_offer", 60);
    for (int k = 0; k < 20; k++) begin
      check("bp_valid", 32'(evt_valid), 1);
      check("bp_id", 32'(evt_id), 4);
      cyc(1);
    end
    evt_ready = 1'b1;
    t_ready = tb_cyc;
    cyc(1);
    check("bp_handshake_count", ev_id_q.size(), 1);
    check("bp_handshake_cycle", ev_cyc_q[0], t_ready);
    cyc(3);
    check("bp_valid_drop", 32'(evt_valid), 0);

    // 5. overflow: three presses on btn0 while its first event is held
    clear_logs();
    evt_ready = 1'b0;
    press(0, 8);
    wait_valid("ovf_offer", 60);
    press(0, 8); cyc(15);
    check("ovf_second_kept", ovf_cnt, 0);
    press(0, 8); cyc(15);
    check("ovf_third_dropped", ovf_cnt, 1);
    evt_ready = 1'b1;
    wait_evt("ovf_evt_count", 2, 60);
    check("ovf_evt0", ev_id_q[0], 0);
    check("ovf_evt1", ev_id_q[1], 0);
    cyc(30);
    check("ovf_no_third", ev_id_q.size(), 2);

    // 6. asynchronous reset while an event is offered
    do_reset();
    evt_ready = 1'b0;
    press(2, 8);
    wait_valid("rst_offer", 60);
    #1 rst_n = 1'b0;
    #1 check("rst_async_valid", 32'(evt_valid), 0);
    cyc(2);
    rst_n = 1'b1;
    clear_logs();
    evt_ready = 1'b1;
    cyc(40);
    check("rst_no_valid", vld_cnt, 0);
    check("rst_no_event", ev_id_q.size(), 0);
    press(3, 8);
    wait_evt("rst_new_evt", 1, 60);
    check("rst_new_id", ev_id_q[0], 3);

    // randomized activity against the model
    do_reset();
    for (int t = 0; t < 4000; t++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 11) == 0) btn_raw[b] = ~btn_raw[b];
      evt_ready = ($urandom_range(0, 3) != 0);
      cyc(1);
    end
    btn_raw = '0;
    evt_ready = 1'b1;
    cyc(100);
    check("rand_evt_count", ev_id_q.size(), m_evcnt);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
